mem_seq_control: RTL and testbench
==================================

Name: mem_seq_control

Overview:
- Parametrised memory-stage sequencer for the MIPS pipeline.
- Handles INT, RTI, RET and CALL as multi-word stack transfers: CALL/INT push, RET/RTI pop.
- Freezes upstream stages via extend while words move, honours memory wait states through mem_ready, then issues a one-cycle jump strobe for the completed operation.
- Sits between EX/MEM decode and the data-memory port; feeds the PC-select logic.

Parameters:
- CNT_W, 2, width of word_idx and the internal word counter.
- INT_WORDS, 2, words pushed for INT (PC and flags); range 0..2**CNT_W.
- RTI_WORDS, 2, words popped for RTI; range 0..2**CNT_W.
- RET_WORDS, 1, words popped for RET; range 0..2**CNT_W.
- CALL_WORDS, 1, words pushed for CALL; range 0..2**CNT_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- int  in  1  interrupt request; level, held by the frozen pipeline until jumpInt.
- rti  in  1  return-from-interrupt request; level.
- ret  in  1  return request; level.
- call  in  1  call request; level.
- mem_ready  in  1  memory accepts/returns the current word this cycle.
- extend  out  1  stall upstream pipeline stages.
- busy  out  1  sequence in progress (state != IDLE).
- mem_push  out  1  current word is a stack write.
- mem_pop  out  1  current word is a stack read.
- word_idx  out  CNT_W  index of the current word, 0-based.
- op  out  2  latched operation: 00 CALL, 01 RET, 10 INT, 11 RTI.
- jumpInt, jumpRti, jumpRet, jumpCall  out  1 each  one-cycle jump strobes.

Behaviour:
- Reset (async, rst=0): state=IDLE, counter=0, op=00. All outputs 0, including extend and every jump strobe. Reset mid-sequence abandons the sequence with no jump.
- Priority when several requests are active: int > rti > ret > call.
- IDLE:
  - extend = int|rti|ret|call (combinational, same cycle).
  - Any request: latch op and N (its word count), counter=0. Next state is XFER if N>0, else JUMP.
- XFER:
  - extend=1, busy=1, word_idx=counter.
  - mem_push=1 for CALL/INT; mem_pop=1 for RET/RTI.
  - mem_ready=0: hold state and counter (wait state).
  - mem_ready=1 and counter<N-1: counter+1.
  - mem_ready=1 and counter==N-1: go to JUMP, counter=0.
- JUMP:
  - extend=0, busy=1. Exactly one strobe matching op is 1. Next state is IDLE unconditionally.
  - Requests in the JUMP cycle are ignored; they belong to the instruction now leaving the stage.
- Requests arriving during XFER or JUMP do not change op. A higher-priority int arriving mid-sequence waits for IDLE.
- Latency with zero wait states: request cycle + N XFER cycles + 1 JUMP cycle. extend is high for N+1 cycles.
- Counter arithmetic is CNT_W bits and never wraps, because N ≤ 2**CNT_W by parameter check.
- Outside XFER: mem_push, mem_pop and word_idx are 0.
- Jump strobes are mutually exclusive and never assert outside JUMP.

Decomposition:
- Package mem_seq_pkg holds:
  - state encoding IDLE/XFER/JUMP (2 bits);
  - op encoding OP_CALL/OP_RET/OP_INT/OP_RTI;
  - a function mapping op to word count from the parameters.
- One sub-module, mem_word_counter: CNT_W-bit counter with clear, enable (mem_ready & XFER) and last (counter==N-1) output.
- Everything else stays in the top FSM.

Test Plan:
- Default params; ret=1 held, mem_ready=1 → extend=1 for 2 cycles, mem_pop=1 with word_idx=0 in cycle 1, jumpRet=1 in cycle 2, busy=0 in cycle 3.
- int=1 held; mem_ready low in cycle 2, then high → word_idx sequence 0,1,1,(JUMP). jumpInt after 4 cycles; mem_push high for 3 cycles.
- int, ret and call asserted together → op=10, 2 pushes, only jumpInt strobes. After int drops with ret still high, the next sequence runs RET.
- CALL_WORDS=0; call=1 → one cycle with extend=1, next cycle jumpCall=1, mem_push never asserted.
- rst pulled low during RTI word 1 → all outputs 0 immediately, no jumpRti. After release, rti=1 restarts from word_idx=0.
- CNT_W=3, RTI_WORDS=8, mem_ready=1 → word_idx 0..7 with no wrap, jumpRti on the 10th cycle.

Source files
------------

// File: rtl/mem_seq_control_pkg.sv
// Shared types for the memory-stage stack sequencer.
// State/op encodings and the op-to-word-count mapping.
package mem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        JUMP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_CALL = 2'b00,
        OP_RET  = 2'b01,
        OP_INT  = 2'b10,
        OP_RTI  = 2'b11
    } op_e;

    // Words moved on the stack for a given operation.
    function automatic int unsigned op_words(
        input op_e         op,
        input int unsigned call_w,
        input int unsigned ret_w,
        input int unsigned int_w,
        input int unsigned rti_w
    );
        int unsigned n;
        case (op)
            OP_CALL: n = call_w;
            OP_RET:  n = ret_w;
            OP_INT:  n = int_w;
            default: n = rti_w;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_seq_control_if.sv
// Request/memory/jump bundle between the MEM-stage decode,
// the stack sequencer and the PC-select logic.
interface mem_seq_control_if
    import mem_seq_pkg::*;
#(
    parameter int CNT_W = 2
) ();

    logic             int_req;
    logic             rti;
    logic             ret;
    logic             call;
    logic             mem_ready;
    logic             extend;
    logic             busy;
    logic             mem_push;
    logic             mem_pop;
    logic [CNT_W-1:0] word_idx;
    op_e              op;
    logic             jumpInt;
    logic             jumpRti;
    logic             jumpRet;
    logic             jumpCall;

    modport master (
        output int_req, rti, ret, call, mem_ready,
        input  extend, busy, mem_push, mem_pop, word_idx, op,
        input  jumpInt, jumpRti, jumpRet, jumpCall
    );

    modport slave (
        input  int_req, rti, ret, call, mem_ready,
        output extend, busy, mem_push, mem_pop, word_idx, op,
        output jumpInt, jumpRti, jumpRet, jumpCall
    );

endinterface

// File: rtl/mem_seq_control_word_counter.sv
// Word counter for stack transfers: clears outside a transfer,
// advances on each accepted word, flags the final word.
module mem_word_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] last_idx,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign last  = (count_q == last_idx);
    assign count = count_q;

    // Next count: hold on wait states, return to 0 after the last word.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = last ? '0 : count_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_seq_control.sv
// MEM-stage sequencer for INT/RTI/RET/CALL stack transfers:
// stalls upstream, steps words on mem_ready, then strobes a jump.
module mem_seq_control
    import mem_seq_pkg::*;
#(
    parameter int          CNT_W      = 2,
    parameter int unsigned INT_WORDS  = 2,
    parameter int unsigned RTI_WORDS  = 2,
    parameter int unsigned RET_WORDS  = 1,
    parameter int unsigned CALL_WORDS = 1
) (
    input logic              clk,
    input logic              rst,
    mem_seq_control_if.slave bus
);

    localparam int unsigned MAX_WORDS = 2 ** CNT_W;

    if (INT_WORDS > MAX_WORDS || RTI_WORDS > MAX_WORDS ||
        RET_WORDS > MAX_WORDS || CALL_WORDS > MAX_WORDS) begin : g_bad_words
        $error("mem_seq_control: word count exceeds 2**CNT_W");
    end

    state_e           state_q;
    state_e           state_d;
    op_e              op_q;
    op_e              op_d;
    op_e              req_op;
    logic             req_any;
    logic [CNT_W:0]   req_n;
    logic [CNT_W:0]   cur_n;
    logic [CNT_W-1:0] last_idx;
    logic [CNT_W-1:0] count;
    logic             last;
    logic             in_idle;
    logic             in_xfer;
    logic             in_jump;
    logic             is_push;

    // Pick the winning request: int > rti > ret > call.
    always_comb begin
        req_any = bus.int_req | bus.rti | bus.ret | bus.call;
        req_op  = OP_CALL;
        if (bus.int_req) begin
            req_op = OP_INT;
        end else if (bus.rti) begin
            req_op = OP_RTI;
        end else if (bus.ret) begin
            req_op = OP_RET;
        end
    end

    assign req_n = (CNT_W+1)'(op_words(req_op, CALL_WORDS,
                                       RET_WORDS, INT_WORDS, RTI_WORDS));
    assign cur_n = (CNT_W+1)'(op_words(op_q, CALL_WORDS,
                                       RET_WORDS, INT_WORDS, RTI_WORDS));
    assign last_idx = CNT_W'(cur_n - (CNT_W+1)'(1));

    assign in_idle = (state_q == IDLE);
    assign in_xfer = (state_q == XFER);
    assign in_jump = (state_q == JUMP);

    mem_word_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (!in_xfer),
        .en       (in_xfer && bus.mem_ready),
        .last_idx (last_idx),
        .count    (count),
        .last     (last)
    );

    // Next state and op latch; requests only sampled in IDLE.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    op_d    = req_op;
                    state_d = (req_n == '0) ? JUMP : XFER;
                end
            end
            XFER: begin
                if (bus.mem_ready && last) begin
                    state_d = JUMP;
                end
            end
            JUMP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and latched operation registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= OP_CALL;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Output decode; extend in IDLE is gated by reset so it is 0 under rst.
    always_comb begin
        is_push       = (op_q == OP_CALL) || (op_q == OP_INT);
        bus.extend    = in_xfer || (in_idle && rst && req_any);
        bus.busy      = !in_idle;
        bus.mem_push  = in_xfer && is_push;
        bus.mem_pop   = in_xfer && !is_push;
        bus.word_idx  = in_xfer ? count : '0;
        bus.op        = op_q;
        bus.jumpInt   = in_jump && (op_q == OP_INT);
        bus.jumpRti   = in_jump && (op_q == OP_RTI);
        bus.jumpRet   = in_jump && (op_q == OP_RET);
        bus.jumpCall  = in_jump && (op_q == OP_CALL);
    end

endmodule

// File: tb/tb_mem_seq_control.sv
// Scoreboard bench for mem_seq_control: three parameterisations,
// directed request sequences, monitors compare every active cycle.
module tb_mem_seq_control;

    localparam logic [1:0] C_CALL = 2'b00;
    localparam logic [1:0] C_RET  = 2'b01;
    localparam logic [1:0] C_INT  = 2'b10;
    localparam logic [1:0] C_RTI  = 2'b11;

    typedef struct packed {
        logic       push;
        logic       pop;
        logic [3:0] idx;
        logic [1:0] op;
        logic [3:0] jmp;
        logic       ext;
        logic       busy;
    } obs_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    obs_t q0[$];
    obs_t q1[$];
    obs_t q2[$];

    mem_seq_control_if #(.CNT_W(2)) ia ();
    mem_seq_control_if #(.CNT_W(2)) ib ();
    mem_seq_control_if #(.CNT_W(3)) ic ();

    mem_seq_control #(
        .CNT_W(2), .INT_WORDS(2), .RTI_WORDS(2),
        .RET_WORDS(1), .CALL_WORDS(1)
    ) ua (.clk(clk), .rst(rst), .bus(ia));

    mem_seq_control #(
        .CNT_W(2), .INT_WORDS(2), .RTI_WORDS(2),
        .RET_WORDS(1), .CALL_WORDS(0)
    ) ub (.clk(clk), .rst(rst), .bus(ib));

    mem_seq_control #(
        .CNT_W(3), .INT_WORDS(2), .RTI_WORDS(8),
        .RET_WORDS(1), .CALL_WORDS(1)
    ) uc (.clk(clk), .rst(rst), .bus(ic));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t obs_a();
        obs_t o;
        o.push = ia.mem_push;
        o.pop  = ia.mem_pop;
        o.idx  = {2'b00, ia.word_idx};
        o.op   = ia.op;
        o.jmp  = {ia.jumpInt, ia.jumpRti, ia.jumpRet, ia.jumpCall};
        o.ext  = ia.extend;
        o.busy = ia.busy;
        return o;
    endfunction

    function automatic obs_t obs_b();
        obs_t o;
        o.push = ib.mem_push;
        o.pop  = ib.mem_pop;
        o.idx  = {2'b00, ib.word_idx};
        o.op   = ib.op;
        o.jmp  = {ib.jumpInt, ib.jumpRti, ib.jumpRet, ib.jumpCall};
        o.ext  = ib.extend;
        o.busy = ib.busy;
        return o;
    endfunction

    function automatic obs_t obs_c();
        obs_t o;
        o.push = ic.mem_push;
        o.pop  = ic.mem_pop;
        o.idx  = {1'b0, ic.word_idx};
        o.op   = ic.op;
        o.jmp  = {ic.jumpInt, ic.jumpRti, ic.jumpRet, ic.jumpCall};
        o.ext  = ic.extend;
        o.busy = ic.busy;
        return o;
    endfunction

    function automatic obs_t ex_word(input bit push, input int idx,
                                     input logic [1:0] op);
        obs_t o;
        o      = '0;
        o.push = push;
        o.pop  = !push;
        o.idx  = 4'(idx);
        o.op   = op;
        o.ext  = 1'b1;
        o.busy = 1'b1;
        return o;
    endfunction

    function automatic obs_t ex_jump(input logic [1:0] op);
        obs_t o;
        o      = '0;
        o.op   = op;
        o.busy = 1'b1;
        case (op)
            C_CALL:  o.jmp = 4'b0001;
            C_RET:   o.jmp = 4'b0010;
            C_RTI:   o.jmp = 4'b0100;
            default: o.jmp = 4'b1000;
        endcase
        return o;
    endfunction

    function automatic obs_t ex_idle(input logic [1:0] op, input bit ext);
        obs_t o;
        o     = '0;
        o.op  = op;
        o.ext = ext;
        return o;
    endfunction

    task automatic pushq(input int i, input obs_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic chk_ev(input int i, input obs_t o, input string nm);
        obs_t e;
        bit   have;
        have = 1'b0;
        e    = '0;
        case (i)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default:
               if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        n_cmp++;
        if (!have) begin
            n_bad++;
            $display("FAIL %s unexpected activity act=%h t=%0t", nm, o, $time);
        end else if (o !== e) begin
            n_bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, o, e, $time);
        end
    endtask

    task automatic chk_dir(input string nm, input obs_t a, input obs_t e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, a, e, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: any push/pop/jump activity must match the next expectation.
    always @(negedge clk) begin
        obs_t o;
        o = obs_a();
        if (o.push || o.pop || (|o.jmp)) chk_ev(0, o, "ev_a");
    end

    always @(negedge clk) begin
        obs_t o;
        o = obs_b();
        if (o.push || o.pop || (|o.jmp)) chk_ev(1, o, "ev_b");
    end

    always @(negedge clk) begin
        obs_t o;
        o = obs_c();
        if (o.push || o.pop || (|o.jmp)) chk_ev(2, o, "ev_c");
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b0;
        ia.int_req = 0; ia.rti = 0; ia.ret = 0; ia.call = 0; ia.mem_ready = 0;
        ib.int_req = 0; ib.rti = 0; ib.ret = 0; ib.call = 0; ib.mem_ready = 0;
        ic.int_req = 0; ic.rti = 0; ic.ret = 0; ic.call = 0; ic.mem_ready = 0;
        #2;
        chk_dir("rst_a", obs_a(), ex_idle(C_CALL, 0));
        chk_dir("rst_b", obs_b(), ex_idle(C_CALL, 0));
        chk_dir("rst_c", obs_c(), ex_idle(C_CALL, 0));
        tick();
        tick();
        rst = 1'b1;
        tick();

        // RET, one word, no wait states
        ia.ret = 1; ia.mem_ready = 1;
        pushq(0, ex_word(0, 0, C_RET));
        pushq(0, ex_jump(C_RET));
        @(negedge clk);
        chk_dir("t1_req", obs_a(), ex_idle(C_CALL, 1));
        tick();
        tick();
        ia.ret = 0;
        tick();
        @(negedge clk);
        chk_dir("t1_idle", obs_a(), ex_idle(C_RET, 0));

        // INT with one wait state on word 1
        tick();
        ia.int_req = 1;
        pushq(0, ex_word(1, 0, C_INT));
        pushq(0, ex_word(1, 1, C_INT));
        pushq(0, ex_word(1, 1, C_INT));
        pushq(0, ex_jump(C_INT));
        tick();
        tick();
        ia.mem_ready = 0;
        tick();
        ia.mem_ready = 1;
        tick();
        ia.int_req = 0;
        tick();

        // INT+RET+CALL together, then RET once INT drops
        ia.int_req = 1; ia.ret = 1; ia.call = 1;
        pushq(0, ex_word(1, 0, C_INT));
        pushq(0, ex_word(1, 1, C_INT));
        pushq(0, ex_jump(C_INT));
        pushq(0, ex_word(0, 0, C_RET));
        pushq(0, ex_jump(C_RET));
        tick();
        tick();
        tick();
        ia.int_req = 0;
        tick();
        @(negedge clk);
        chk_dir("t3_ret_req", obs_a(), ex_idle(C_INT, 1));
        tick();
        tick();
        ia.ret = 0; ia.call = 0;
        tick();

        // CALL with zero words
        ib.call = 1;
        pushq(1, ex_jump(C_CALL));
        @(negedge clk);
        chk_dir("b_req", obs_b(), ex_idle(C_CALL, 1));
        tick();
        ib.call = 0;
        tick();

        // Reset during RTI word 1, then restart
        ia.rti = 1;
        pushq(0, ex_word(0, 0, C_RTI));
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_dir("a_rst_mid", obs_a(), ex_idle(C_CALL, 0));
        tick();
        tick();
        rst = 1'b1;
        pushq(0, ex_word(0, 0, C_RTI));
        pushq(0, ex_word(0, 1, C_RTI));
        pushq(0, ex_jump(C_RTI));
        tick();
        tick();
        tick();
        ia.rti = 0;
        tick();
        @(negedge clk);
        chk_dir("a_after_rti", obs_a(), ex_idle(C_RTI, 0));

        // RTI with 8 words on CNT_W=3
        tick();
        ic.rti = 1; ic.mem_ready = 1;
        for (int i = 0; i < 8; i++) pushq(2, ex_word(0, i, C_RTI));
        pushq(2, ex_jump(C_RTI));
        repeat (9) tick();
        ic.rti = 0;
        tick();

        k = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && k < 20) begin
            @(posedge clk);
            k++;
        end
        n_cmp++;
        if ((q0.size() + q1.size() + q2.size()) != 0) begin
            n_bad++;
            $display("FAIL drain pending act=%0d/%0d/%0d exp=0",
                     q0.size(), q1.size(), q2.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
